lfsr_checker: RTL and testbench
===============================

Name: lfsr_checker

Overview:
- Serial receive-side checker for the bit stream produced by our Galois LFSR generator, which uses the same width/polynom parameters.
- Self-synchronises to the incoming stream by predicting each next bit from its recent history, then declares lock.
- Once locked, it free-runs, flags every mismatching bit and keeps a saturating error count.
- Sits at the sink end of PRBS test links and is paired with the lfsr generator.

Parameters:
- width, 32, generator register length in bits; must be >= 2.
- polynom, {width{1'b0}}, generator tap vector; bit polynom[width-1] is unused.
- lock_len, 64, consecutive correct predictions required to declare lock.
- bad_limit, 8, mismatches while locked that force a return to hunting.
- cnt_width, 16, width of err_count.

Ports:
- clk  in  1  clock, rising edge.
- res_n  in  1  asynchronous active-low reset.
- enable  in  1  d_in is valid this cycle; all state advances only when high.
- clear  in  1  synchronous clear, takes priority over enable.
- d_in  in  1  received serial bit, sampled on clk when enable=1.
- locked  out  1  checker is in LOCKED state.
- err  out  1  one-cycle pulse: the bit sampled in the previous cycle mismatched while LOCKED.
- err_count  out  cnt_width  saturating count of mismatches seen while LOCKED.

Behaviour:
- Reset:
  - Async on res_n=0: state=HUNT; history, fill, good and miss counters = 0; locked=0, err=0, err_count=0.
  - clear=1 at a clock edge has the same effect, synchronously, regardless of enable.
- History h[width-1:0]: h[0] is the newest bit.
  - Shift step: h <= {h[width-2:0], b}.
  - Prediction: pred = h[width-1] XOR (XOR over j=0..width-2 of polynom[j] AND h[width-2-j]).
  - This is the exact output recurrence of the Galois generator (msb output, data[0]<=msb, data[i]<=data[i-1]^(polynom[i-1]&msb)).
- enable=0: all state holds; err=0 the next cycle.
- HUNT:
  - Each enabled bit: shift in d_in, increment fill.
  - After width enabled bits (fill==width-1 at the edge), go to VERIFY with good=0. No comparisons are made in HUNT.
- VERIFY:
  - Each enabled bit: compare d_in with pred, then shift in d_in (self-synchronising).
  - Match: good++.
  - Mismatch: good=0, stay in VERIFY.
  - When the lock_len-th consecutive match is sampled and the resulting h != 0: go to LOCKED, miss=0. If h==0 (all-zero stream), good holds at lock_len and the checker stays in VERIFY; an all-zero stream never locks.
- LOCKED:
  - Each enabled bit: shift in pred, not d_in, so one line error is counted exactly once.
  - Mismatch: err=1 the next cycle; err_count++ saturating at 2^cnt_width-1; miss++.
  - lock_len consecutive matches: miss=0.
  - When miss reaches bad_limit: go to HUNT with fill=0. err_count is retained; it is cleared only by clear or reset.
- Outputs:
  - locked is registered (=state==LOCKED).
  - Latency from the sampling edge of the deciding bit to locked/err change is one clock.
- Arithmetic: counters are sized to hold their limits (clog2 of width, lock_len, bad_limit) and never wrap.
- Simultaneous events:
  - clear beats enable.
  - A mismatch that both saturates err_count and reaches bad_limit still pulses err and leaves LOCKED.
- Reset mid-operation: everything returns to HUNT immediately; no partial counts survive.

Test Plan:
1. Fill and lock:
   - Setup: width=4, polynom=4'b0001, lock_len=8, bad_limit=3; generator seeded 4'b1000; enable held 1 (period-15 sequence).
   - Required: locked=0 for the first 12 enabled bits, locked=1 on the cycle after the 12th bit, err never pulses.
2. Single error:
   - Stimulus: after lock, invert one bit.
   - Required: err=1 for exactly one cycle, err_count=1, locked stays 1, following bits produce no err.
3. Loss of lock:
   - Stimulus: invert 3 bits within 8 consecutive bits.
   - Required: err pulses 3 times, err_count=3, locked falls the cycle after the 3rd error; relock after 12 more clean bits with err_count still 3.
4. All-zero input:
   - Stimulus: d_in=0 for 100 enabled cycles.
   - Required: locked stays 0, err_count stays 0.
5. Enable gaps:
   - Stimulus: insert random enable=0 cycles during scenario 1.
   - Required: lock after exactly 12 enabled bits; state frozen during gaps.
6. Clear and reset:
   - Stimulus: clear=1 for one cycle while locked with err_count=2.
   - Required: next cycle locked=0, err_count=0.
   - Stimulus: res_n low asynchronously mid-VERIFY.
   - Required: outputs go to 0 without a clock edge.

Source files
------------

// File: rtl/lfsr_checker.sv
// ---------------------------------------------------------------------------
// lfsr_checker
//
// Receive-side checker for the serial bit stream of the Galois LFSR
// generator that uses the same width/polynom parameters.
//
// The checker first collects `width` bits of history (HUNT). It then predicts
// every following bit from that history and counts consecutive correct
// predictions (VERIFY). After lock_len matches on a non-zero history it
// declares lock (LOCKED). From then on it runs on its own predictions, flags
// each mismatching line bit with a one-cycle err pulse and keeps a saturating
// error count. Too many errors inside one clean window drop it back to HUNT.
//
// Parameters
//   width      generator register length in bits (>= 2)
//   polynom    generator tap vector, bit [width-1] unused
//   lock_len   consecutive correct predictions needed to declare lock
//   bad_limit  mismatches while locked that force a return to HUNT
//   cnt_width  width of err_count
//
// Ports
//   clk        clock, rising edge
//   res_n      asynchronous active-low reset
//   enable     d_in is valid this cycle; all state advances only when high
//   clear      synchronous clear, wins over enable
//   d_in       received serial bit
//   locked     registered: checker is in LOCKED
//   err        one-cycle pulse, previous sampled bit mismatched while LOCKED
//   err_count  saturating count of mismatches seen while LOCKED
// ---------------------------------------------------------------------------
module lfsr_checker #(
    parameter int               width     = 32,
    parameter logic [width-1:0] polynom   = {width{1'b0}},
    parameter int               lock_len  = 64,
    parameter int               bad_limit = 8,
    parameter int               cnt_width = 16
) (
    input  logic                 clk,
    input  logic                 res_n,
    input  logic                 enable,
    input  logic                 clear,
    input  logic                 d_in,
    output logic                 locked,
    output logic                 err,
    output logic [cnt_width-1:0] err_count
);

    // Counter widths are chosen so each counter can hold its own limit.
    localparam int fill_w = $clog2(width);
    localparam int good_w = $clog2(lock_len + 1);
    localparam int miss_w = $clog2(bad_limit + 1);

    localparam logic [fill_w-1:0]    fill_last = fill_w'(width - 1);
    localparam logic [good_w-1:0]    good_max  = good_w'(lock_len);
    localparam logic [miss_w-1:0]    miss_max  = miss_w'(bad_limit);
    localparam logic [cnt_width-1:0] cnt_max   = {cnt_width{1'b1}};

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } state_t;

    state_t             state;
    logic [width-1:0]   hist;
    logic [fill_w-1:0]  fill;
    logic [good_w-1:0]  good;
    logic [miss_w-1:0]  miss;

    logic               pred;
    logic               match;
    logic [width-1:0]   hist_line;
    logic [width-1:0]   hist_pred;
    logic [good_w-1:0]  good_inc;
    logic [good_w-1:0]  good_sat;
    logic [miss_w-1:0]  miss_inc;

    // Next-bit prediction. The newest bit sits in hist[0], so the bit that
    // the generator's msb tap sees is hist[width-1], and tap polynom[j]
    // pairs with the bit that was received width-2-j steps ago. This is the
    // output recurrence of the Galois generator written in terms of its
    // past output bits only.
    always_comb begin
        pred = hist[width-1];
        for (int j = 0; j < width - 1; j++) begin
            pred = pred ^ (polynom[j] & hist[width-2-j]);
        end
    end

    // Candidate history updates and counter increments. In HUNT/VERIFY the
    // line bit is shifted in so the checker synchronises to the stream; in
    // LOCKED the predicted bit is shifted in so a single flipped line bit
    // cannot corrupt the history and is counted exactly once.
    always_comb begin
        match     = (d_in == pred);
        hist_line = {hist[width-2:0], d_in};
        hist_pred = {hist[width-2:0], pred};
        good_inc  = good + 1'b1;
        good_sat  = (good == good_max) ? good : good_inc;
        miss_inc  = miss + 1'b1;
    end

    // Main state machine. Every register, including the outputs, lives in
    // this one block so locked/err change exactly one clock after the edge
    // that sampled the deciding bit. A clear behaves like the async reset
    // but synchronously and regardless of enable. err defaults to 0 so it
    // is a single-cycle pulse and drops during enable gaps.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state     <= HUNT;
            hist      <= '0;
            fill      <= '0;
            good      <= '0;
            miss      <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
        end else if (clear) begin
            state     <= HUNT;
            hist      <= '0;
            fill      <= '0;
            good      <= '0;
            miss      <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            err <= 1'b0;
            if (enable) begin
                case (state)
                    HUNT: begin
                        hist <= hist_line;
                        if (fill == fill_last) begin
                            state <= VERIFY;
                            fill  <= '0;
                            good  <= '0;
                        end else begin
                            fill <= fill + 1'b1;
                        end
                    end

                    VERIFY: begin
                        hist <= hist_line;
                        if (match) begin
                            // An all-zero history trivially predicts itself,
                            // so lock is refused until a non-zero pattern is
                            // confirmed; good parks at its limit meanwhile.
                            if ((good_sat == good_max) && (hist_line != '0)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                                good   <= '0;
                                miss   <= '0;
                            end else begin
                                good <= good_sat;
                            end
                        end else begin
                            good <= '0;
                        end
                    end

                    LOCKED: begin
                        hist <= hist_pred;
                        if (match) begin
                            // A full clean window forgives earlier misses.
                            if (good_inc == good_max) begin
                                good <= '0;
                                miss <= '0;
                            end else begin
                                good <= good_inc;
                            end
                        end else begin
                            err  <= 1'b1;
                            good <= '0;
                            if (err_count != cnt_max) begin
                                err_count <= err_count + 1'b1;
                            end
                            // err_count survives the loss of lock on purpose.
                            if (miss_inc == miss_max) begin
                                state  <= HUNT;
                                locked <= 1'b0;
                                fill   <= '0;
                                miss   <= '0;
                            end else begin
                                miss <= miss_inc;
                            end
                        end
                    end

                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                        fill   <= '0;
                        good   <= '0;
                        miss   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// ---------------------------------------------------------------------------
// tb_lfsr_checker
//
// Self-checking bench for lfsr_checker (width=4, polynom=4'b0001,
// lock_len=8, bad_limit=3, cnt_width=3). Stimulus comes from a Galois
// generator model; a behavioural checker model (history kept as a bit queue,
// plain integer counters) predicts locked/err/err_count every cycle.
// Directed scenarios add fixed-value checks on top.
// ---------------------------------------------------------------------------
module tb_lfsr_checker;

    localparam int           W    = 4;
    localparam logic [W-1:0] P    = 4'b0001;
    localparam int           LOCK = 8;
    localparam int           BAD  = 3;
    localparam int           CW   = 3;

    logic          clk = 1'b0;
    logic          res_n;
    logic          enable;
    logic          clear;
    logic          d_in;
    logic          locked;
    logic          err;
    logic [CW-1:0] err_count;

    int errors = 0;
    int checks = 0;

    lfsr_checker #(
        .width     (W),
        .polynom   (P),
        .lock_len  (LOCK),
        .bad_limit (BAD),
        .cnt_width (CW)
    ) dut (
        .clk       (clk),
        .res_n     (res_n),
        .enable    (enable),
        .clear     (clear),
        .d_in      (d_in),
        .locked    (locked),
        .err       (err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    // Generator model: plain Galois LFSR, msb is the output bit.
    logic [W-1:0] gen_reg;

    function automatic logic gen_next();
        logic         out_bit;
        logic [W-1:0] taps;
        logic [W-1:0] nxt;
        taps    = P;
        out_bit = gen_reg[W-1];
        nxt[0]  = out_bit;
        for (int i = 1; i < W; i++) nxt[i] = gen_reg[i-1] ^ (taps[i-1] & out_bit);
        gen_reg = nxt;
        return out_bit;
    endfunction

    // Checker model: history as a queue, index 0 = newest bit.
    typedef enum {M_HUNT, M_VERIFY, M_LOCKED} mstate_t;
    mstate_t m_state;
    bit      m_hist[$];
    int      m_fill, m_good, m_miss, m_cnt;
    bit      m_locked, m_err;

    task automatic model_reset();
        m_state = M_HUNT;
        m_hist.delete();
        for (int i = 0; i < W; i++) m_hist.push_back(1'b0);
        m_fill = 0; m_good = 0; m_miss = 0; m_cnt = 0;
        m_locked = 1'b0; m_err = 1'b0;
    endtask

    function automatic bit model_pred();
        logic [W-1:0] taps;
        bit           p;
        taps = P;
        p = m_hist[W-1];
        for (int j = 0; j < W - 1; j++) if (taps[j]) p = p ^ m_hist[W-2-j];
        return p;
    endfunction

    function automatic bit model_hist_nonzero();
        for (int i = 0; i < W; i++) if (m_hist[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_push(input bit b);
        m_hist.push_front(b);
        void'(m_hist.pop_back());
    endtask

    task automatic model_step(input bit clr, input bit en, input bit d);
        bit p;
        m_err = 1'b0;
        if (clr) begin
            model_reset();
        end else if (en) begin
            p = model_pred();
            case (m_state)
                M_HUNT: begin
                    model_push(d);
                    m_fill++;
                    if (m_fill == W) begin
                        m_state = M_VERIFY;
                        m_fill = 0;
                        m_good = 0;
                    end
                end
                M_VERIFY: begin
                    model_push(d);
                    if (d == p) begin
                        if (m_good < LOCK) m_good++;
                        if (m_good == LOCK && model_hist_nonzero()) begin
                            m_state = M_LOCKED;
                            m_good = 0;
                            m_miss = 0;
                        end
                    end else begin
                        m_good = 0;
                    end
                end
                default: begin
                    model_push(p);
                    if (d == p) begin
                        m_good++;
                        if (m_good == LOCK) begin
                            m_good = 0;
                            m_miss = 0;
                        end
                    end else begin
                        m_err = 1'b1;
                        if (m_cnt < (1 << CW) - 1) m_cnt++;
                        m_good = 0;
                        m_miss++;
                        if (m_miss == BAD) begin
                            m_state = M_HUNT;
                            m_fill = 0;
                            m_miss = 0;
                        end
                    end
                end
            endcase
        end
        m_locked = (m_state == M_LOCKED);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    // One clock: drive inputs, let the edge happen, compare DUT to model.
    task automatic applyStimulus(input bit en, input bit clr, input bit d);
        enable = en;
        clear  = clr;
        d_in   = d;
        @(posedge clk);
        #1;
        model_step(clr, en, d);
        checkOutput("locked", 32'(locked), 32'(m_locked));
        checkOutput("err", 32'(err), 32'(m_err));
        checkOutput("err_count", 32'(err_count), 32'(m_cnt));
    endtask

    // Asynchronous reset pulse away from any clock edge.
    task automatic asyncReset();
        #3;
        res_n = 1'b0;
        #1;
        checkOutput("async_locked", 32'(locked), 32'd0);
        checkOutput("async_err", 32'(err), 32'd0);
        checkOutput("async_err_count", 32'(err_count), 32'd0);
        model_reset();
        #2;
        res_n = 1'b1;
    endtask

    initial begin
        int lock_at;
        int pulses;
        int en_bits;
        bit seen_lock;
        bit b;
        bit en;

        res_n  = 1'b0;
        enable = 1'b0;
        clear  = 1'b0;
        d_in   = 1'b0;
        model_reset();
        #12;
        checkOutput("reset_locked", 32'(locked), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        checkOutput("reset_err_count", 32'(err_count), 32'd0);
        res_n = 1'b1;

        // Fill and lock.
        gen_reg = 4'b1000;
        lock_at = 0;
        pulses  = 0;
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, 1'b0, gen_next());
            if (locked && lock_at == 0) lock_at = i;
            if (err) pulses++;
        end
        checkOutput("s1_lock_at", 32'(lock_at), 32'd12);
        checkOutput("s1_err_pulses", 32'(pulses), 32'd0);

        // Single error while locked.
        applyStimulus(1'b1, 1'b0, gen_next() ^ 1'b1);
        checkOutput("s2_err_pulse", 32'(err), 32'd1);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, gen_next());
            if (err) pulses++;
        end
        checkOutput("s2_no_more_err", 32'(pulses), 32'd0);
        checkOutput("s2_err_count", 32'(err_count), 32'd1);
        checkOutput("s2_locked", 32'(locked), 32'd1);

        // Second isolated error, then clear while locked with err_count=2.
        applyStimulus(1'b1, 1'b0, gen_next() ^ 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, gen_next());
        checkOutput("s6_pre_count", 32'(err_count), 32'd2);
        applyStimulus(1'b1, 1'b1, gen_next());
        checkOutput("s6_clear_locked", 32'(locked), 32'd0);
        checkOutput("s6_clear_count", 32'(err_count), 32'd0);

        // Relock after clear.
        lock_at = 0;
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(1'b1, 1'b0, gen_next());
            if (locked && lock_at == 0) lock_at = i;
        end
        checkOutput("s6_relock_at", 32'(lock_at), 32'd12);

        // Loss of lock: errors at offsets 0, 2, 4.
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            b = gen_next();
            if (i % 2 == 0) b = ~b;
            applyStimulus(1'b1, 1'b0, b);
            if (err) pulses++;
            if (i == 3) checkOutput("s3_still_locked", 32'(locked), 32'd1);
        end
        checkOutput("s3_err_pulses", 32'(pulses), 32'd3);
        checkOutput("s3_lost_lock", 32'(locked), 32'd0);
        checkOutput("s3_err_count", 32'(err_count), 32'd3);
        lock_at = 0;
        for (int i = 1; i <= 14; i++) begin
            applyStimulus(1'b1, 1'b0, gen_next());
            if (locked && lock_at == 0) lock_at = i;
        end
        checkOutput("s3_relock_at", 32'(lock_at), 32'd12);
        checkOutput("s3_count_kept", 32'(err_count), 32'd3);

        // Lose lock again, move into VERIFY, then reset asynchronously.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, gen_next() ^ 1'b1);
        checkOutput("s6_count6", 32'(err_count), 32'd6);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, gen_next());
        asyncReset();

        // All-zero input never locks.
        seen_lock = 1'b0;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            if (locked) seen_lock = 1'b1;
        end
        checkOutput("s4_never_locked", 32'(seen_lock), 32'd0);
        checkOutput("s4_err_count", 32'(err_count), 32'd0);

        // Enable gaps with garbage on d_in while disabled.
        asyncReset();
        gen_reg = 4'b1000;
        en_bits = 0;
        lock_at = 0;
        for (int i = 0; i < 40; i++) begin
            en = ($urandom_range(0, 2) != 0);
            b  = en ? gen_next() : 1'($urandom_range(0, 1));
            applyStimulus(en, 1'b0, b);
            if (en) en_bits++;
            if (locked && lock_at == 0) lock_at = en_bits;
        end
        checkOutput("s5_lock_at", 32'(lock_at), 32'd12);

        // Randomised soak against the model.
        asyncReset();
        gen_reg = 4'($urandom_range(1, 15));
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 4) != 0);
            b  = en ? (gen_next() ^ ($urandom_range(0, 19) == 0)) : 1'($urandom_range(0, 1));
            applyStimulus(en, ($urandom_range(0, 499) == 0), b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
